// File: rtl/axis_pkg.sv
// rtl/axis_pkg.sv - shared constants for the FIR output stream buffer
package axis_pkg;
  localparam int AXIS_DATA_W = 32;
  localparam int AXIS_DEPTH  = 8;
  localparam int AXIS_FCNT_W = 16;
endpackage

// File: rtl/fifo_regfile.sv
// rtl/fifo_regfile.sv - DEPTH x (DATA_W+1) storage, one sync write port, one comb read port
module fifo_regfile
  import axis_pkg::*;
#(
  parameter int DATA_W = AXIS_DATA_W,
  parameter int DEPTH  = AXIS_DEPTH,
  parameter int ADDR_W = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [DATA_W:0]   wr_data,
  input  logic [ADDR_W-1:0] rd_addr,
  output logic [DATA_W:0]   rd_data
);

  // Unreset on purpose: an entry is only ever read after it has been written.
  logic [DATA_W:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_addr] <= wr_data;
  end

  assign rd_data = mem[rd_addr];

endmodule

// File: rtl/axis_out_fifo.sv
// rtl/axis_out_fifo.sv - first-word fall-through FIFO on the FIR result stream with level and frame count
module axis_out_fifo
  import axis_pkg::*;
#(
  parameter int DATA_W = AXIS_DATA_W,
  parameter int DEPTH  = AXIS_DEPTH,
  parameter int ADDR_W = $clog2(DEPTH),
  parameter int FCNT_W = AXIS_FCNT_W
) (
  input  logic              axis_clk,
  input  logic              axis_rst_n,
  input  logic              clr,
  input  logic              s_tvalid,
  input  logic [DATA_W-1:0] s_tdata,
  input  logic              s_tlast,
  output logic              s_tready,
  output logic              m_tvalid,
  output logic [DATA_W-1:0] m_tdata,
  output logic              m_tlast,
  input  logic              m_tready,
  output logic [ADDR_W:0]   level,
  output logic [FCNT_W-1:0] frame_cnt
);

  localparam logic [ADDR_W:0]   LVL_FULL = (ADDR_W+1)'(DEPTH);
  localparam logic [ADDR_W:0]   LVL_ONE  = (ADDR_W+1)'(1);
  localparam logic [ADDR_W-1:0] PTR_ONE  = ADDR_W'(1);
  localparam logic [FCNT_W-1:0] CNT_ONE  = FCNT_W'(1);

  logic [ADDR_W-1:0] wr_ptr;
  logic [ADDR_W-1:0] rd_ptr;
  logic [ADDR_W:0]   level_nxt;
  logic [DATA_W:0]   head;
  logic              push;
  logic              pop;

  assign push = s_tvalid & s_tready;
  assign pop  = m_tvalid & m_tready;

  always_comb begin
    level_nxt = level;
    case ({push, pop})
      2'b10:   level_nxt = level + LVL_ONE;
      2'b01:   level_nxt = level - LVL_ONE;
      default: level_nxt = level;
    endcase
  end

  // s_tready is precomputed from the next level so a full FIFO never accepts, even while popping.
  always_ff @(posedge axis_clk or negedge axis_rst_n) begin
    if (!axis_rst_n) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      level     <= '0;
      frame_cnt <= '0;
      s_tready  <= 1'b0;
    end else if (clr) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      level     <= '0;
      frame_cnt <= '0;
      s_tready  <= 1'b1;
    end else begin
      if (push) wr_ptr <= wr_ptr + PTR_ONE;
      if (pop)  rd_ptr <= rd_ptr + PTR_ONE;
      if (pop && m_tlast) frame_cnt <= frame_cnt + CNT_ONE;
      level    <= level_nxt;
      s_tready <= (level_nxt != LVL_FULL);
    end
  end

  fifo_regfile #(
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH),
    .ADDR_W (ADDR_W)
  ) u_regfile (
    .clk     (axis_clk),
    .wr_en   (push & ~clr),
    .wr_addr (wr_ptr),
    .wr_data ({s_tlast, s_tdata}),
    .rd_addr (rd_ptr),
    .rd_data (head)
  );

  // Gating by m_tvalid keeps the outputs at 0 when empty, including immediately on reset.
  assign m_tvalid = (level != '0);
  assign m_tdata  = m_tvalid ? head[DATA_W-1:0] : '0;
  assign m_tlast  = m_tvalid & head[DATA_W];

endmodule
